// File: rtl/vga_fbuff_tile_writer_if.sv
// Tile write-request port plus frame-buffer bus of the tile writer.
// The writer binds the slave modport; the requester/memory side binds master.
interface vga_fbuff_tile_writer_if #(
  parameter int pxl_width_g        = 12,
  parameter int fbuff_addr_width_g = 15,
  parameter int fbuff_data_width_g = 48,
  parameter int tile_x_width_g     = 9,
  parameter int tile_y_width_g     = 8
);
  logic                          wr_valid_i;
  logic                          wr_ready_o;
  logic [tile_x_width_g-1:0]     wr_tile_x_i;
  logic [tile_y_width_g-1:0]     wr_tile_y_i;
  logic [pxl_width_g-1:0]        wr_pxl_i;
  logic [fbuff_addr_width_g-1:0] fbuff_addr_o;
  logic                          fbuff_en_o;
  logic                          fbuff_wen_o;
  logic [fbuff_data_width_g-1:0] fbuff_data_o;
  logic                          fbuff_rd_req_o;
  logic                          fbuff_rd_rsp_i;
  logic [fbuff_data_width_g-1:0] fbuff_data_i;

  modport slave (
    input  wr_valid_i, wr_tile_x_i, wr_tile_y_i, wr_pxl_i, fbuff_rd_rsp_i, fbuff_data_i,
    output wr_ready_o, fbuff_addr_o, fbuff_en_o, fbuff_wen_o, fbuff_data_o, fbuff_rd_req_o
  );

  modport master (
    output wr_valid_i, wr_tile_x_i, wr_tile_y_i, wr_pxl_i, fbuff_rd_rsp_i, fbuff_data_i,
    input  wr_ready_o, fbuff_addr_o, fbuff_en_o, fbuff_wen_o, fbuff_data_o, fbuff_rd_req_o
  );
endinterface

// File: rtl/vga_fbuff_tile_writer.sv
// Frame-buffer tile writer: read-modify-write of one tile into its packed row word.
// Optional macro VGA_FBUFF_WR_BOUNDS_CHECK_EN drops out-of-range writes and pulses wr_err_o.
module vga_fbuff_tile_writer #(
  parameter int pxl_width_g        = 12,
  parameter int tile_per_line_g    = 320,
  parameter int tile_lines_g       = 240,
  parameter int tiles_per_row_g    = 4,
  parameter int fbuff_addr_width_g = 15,
  parameter int fbuff_data_width_g = 48,
  parameter int tile_x_width_g     = 9,
  parameter int tile_y_width_g     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  vga_fbuff_tile_writer_if.slave bus_if,
  output logic                   busy_o,
  output logic                   wr_err_o
);
  localparam int ROW_WORDS = tile_per_line_g / tiles_per_row_g;
  localparam int SLOT_W    = (tiles_per_row_g > 1) ? $clog2(tiles_per_row_g) : 1;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WRITE} state_t;

  state_t                        r_state, w_state_nxt;
  logic [fbuff_addr_width_g-1:0] r_addr, w_addr;
  logic [SLOT_W-1:0]             r_slot, w_slot;
  logic [pxl_width_g-1:0]        r_pxl;
  logic [fbuff_data_width_g-1:0] r_data, w_data_nxt, w_word;
  logic                          r_en, r_wen, r_rd_req, r_busy, r_err;
  logic                          w_en_nxt, w_wen_nxt, w_rd_req_nxt, w_err_nxt;
  logic                          w_ready, w_hs, w_oob;

  assign w_ready = (r_state == IDLE) & ~rst_i;
  assign w_hs    = bus_if.wr_valid_i & w_ready;

  assign w_addr = fbuff_addr_width_g'(bus_if.wr_tile_y_i) * fbuff_addr_width_g'(ROW_WORDS)
                + fbuff_addr_width_g'(bus_if.wr_tile_x_i / tile_x_width_g'(tiles_per_row_g));
  assign w_slot = SLOT_W'(bus_if.wr_tile_x_i % tile_x_width_g'(tiles_per_row_g));

`ifdef VGA_FBUFF_WR_BOUNDS_CHECK_EN
  assign w_oob = (int'(bus_if.wr_tile_x_i) >= tile_per_line_g)
               | (int'(bus_if.wr_tile_y_i) >= tile_lines_g);
`else
  assign w_oob = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Outputs are computed from the next state so they line up with the state register.
  always_comb begin
    w_state_nxt  = r_state;
    w_en_nxt     = 1'b0;
    w_wen_nxt    = 1'b0;
    w_rd_req_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    w_data_nxt   = '0;
    w_word       = bus_if.fbuff_data_i;
    w_word[int'(r_slot) * pxl_width_g +: pxl_width_g] = r_pxl;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          if (w_oob) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt  = RD_REQ;
            w_en_nxt     = 1'b1;
            w_rd_req_nxt = 1'b1;
          end
        end
      end
      RD_REQ: begin
        w_state_nxt = RD_WAIT;
        w_en_nxt    = 1'b1;
      end
      RD_WAIT: begin
        w_en_nxt = 1'b1;
        if (bus_if.fbuff_rd_rsp_i) begin
          w_state_nxt = WRITE;
          w_wen_nxt   = 1'b1;
          w_data_nxt  = w_word;
        end
      end
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr   <= '0;
      r_slot   <= '0;
      r_pxl    <= '0;
      r_data   <= '0;
      r_en     <= 1'b0;
      r_wen    <= 1'b0;
      r_rd_req <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs && !w_oob) begin
        r_addr <= w_addr;
        r_slot <= w_slot;
        r_pxl  <= bus_if.wr_pxl_i;
      end
      r_data   <= w_data_nxt;
      r_en     <= w_en_nxt;
      r_wen    <= w_wen_nxt;
      r_rd_req <= w_rd_req_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_err    <= w_err_nxt;
    end
  end

  assign bus_if.wr_ready_o     = w_ready;
  assign bus_if.fbuff_addr_o   = r_addr;
  assign bus_if.fbuff_en_o     = r_en;
  assign bus_if.fbuff_wen_o    = r_wen;
  assign bus_if.fbuff_data_o   = r_data;
  assign bus_if.fbuff_rd_req_o = r_rd_req;
  assign busy_o                = r_busy;
  assign wr_err_o              = r_err;
endmodule
